// File: rtl/sdram_frame_reader.sv
// Fetches one contiguous frame from SDRAM with Avalon-MM bursts and replays it as a marked video stream.
// Latency: first read 2 cycles after start; readdatavalid to stream valid is at least 2 cycles.
// Backpressure: out_enable=0 holds words in the FIFO, and bursts are issued only when the FIFO has room for them.

// Small synchronous FIFO that absorbs the returning bursts.
// Latency: a word written in cycle N can be popped in cycle N+1; pop_data is read combinationally from the head.
// Backpressure: none inside the FIFO; the owner guarantees it never pushes when the FIFO is full.
module sdram_frame_reader_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] used
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign empty    = (used == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; the contents need no reset because used gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and fill level; a push and a pop in the same cycle leave used unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end
endmodule

// Burst-read DMA stage: SDRAM frame to Avalon-ST video stream with sop/eop/sof/eof markers.
// Latency: read rises 2 cycles after start; a stream word appears 2 cycles after its readdatavalid at minimum.
// Backpressure: out_enable=0 stalls output; reads are credit-limited so the FIFO never overflows.
module sdram_frame_reader #(
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_DATA = 64,
    parameter int BURST_LEN  = 16,
    parameter int LINE_WORDS = 28,
    parameter int LINES      = 28,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH_ADDR-1:0] base_addr,
    input  logic                  out_enable,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH_ADDR-1:0] address,
    output logic [7:0]            burstcount,
    output logic                  read,
    input  logic                  waitrequest,
    input  logic [WIDTH_DATA-1:0] readdata,
    input  logic                  readdatavalid,
    output logic [WIDTH_DATA-1:0] data,
    output logic                  valid,
    output logic                  sop,
    output logic                  eop,
    output logic                  sof,
    output logic                  eof
);
    localparam int TOTAL = LINE_WORDS * LINES;
    localparam int CW_T  = $clog2(TOTAL + 1);
    localparam int CW_F  = $clog2(FIFO_DEPTH + 1);
    localparam int CW_A  = (CW_T > CW_F) ? CW_T : CW_F;
    // Counters share one width wide enough for TOTAL, FIFO_DEPTH and an 8-bit burstcount.
    localparam int CW    = (CW_A > 8) ? CW_A : 8;
    localparam int UW    = $clog2(FIFO_DEPTH + 1);
    localparam int LW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_C    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_REQ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   req_cnt;
    logic [CW-1:0]   rx_cnt;
    logic [CW-1:0]   tx_cnt;
    logic [LW-1:0]   word_in_line;

    logic [CW-1:0]   remaining;
    logic [CW-1:0]   burst_calc;
    logic [CW-1:0]   burst_ext;
    logic [CW-1:0]   pending;
    logic            credit_ok;
    logic            accept;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [UW-1:0]   fifo_used;
    logic [WIDTH_DATA-1:0] fifo_data;

    // Words still owed by SDRAM plus words already buffered must leave room for the whole next burst.
    assign remaining  = TOTAL_C - req_cnt;
    assign burst_calc = (remaining > BURST_C) ? BURST_C : remaining;
    assign burst_ext  = CW'(burstcount);
    assign pending    = (req_cnt - rx_cnt) + CW'(fifo_used);
    assign credit_ok  = (DEPTH_C - pending) >= burst_calc;
    assign accept     = (state == S_REQ) && !waitrequest;

    // Returns arriving while idle are stale (e.g. left over from an aborted frame) and are dropped.
    assign fifo_push  = readdatavalid && (state != S_IDLE);
    assign fifo_pop   = !fifo_empty && out_enable && (state != S_IDLE);

    sdram_frame_reader_fifo #(
        .WIDTH (WIDTH_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (readdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .used      (fifo_used)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded request/status outputs.
    always_comb begin
        state_next = state;
        read       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CREDIT;
                end
            end
            S_CREDIT: begin
                busy = 1'b1;
                if (credit_ok) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                busy = 1'b1;
                read = 1'b1;
                if (!waitrequest) begin
                    state_next = ((req_cnt + burst_ext) == TOTAL_C) ? S_DRAIN : S_CREDIT;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (tx_cnt == TOTAL_C) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request address/size and the progress counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            address      <= '0;
            burstcount   <= '0;
            req_cnt      <= '0;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            word_in_line <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                address      <= base_addr;
                req_cnt      <= '0;
                rx_cnt       <= '0;
                tx_cnt       <= '0;
                word_in_line <= '0;
            end
        end else begin
            // burstcount is frozen on entry to REQ so it stays stable through waitrequest.
            if ((state == S_CREDIT) && credit_ok) begin
                burstcount <= burst_calc[7:0];
            end
            if (accept) begin
                address <= address + WIDTH_ADDR'(burstcount);
                req_cnt <= req_cnt + burst_ext;
            end
            if (fifo_push) begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (fifo_pop) begin
                tx_cnt       <= tx_cnt + 1'b1;
                word_in_line <= (word_in_line == LINE_LAST) ? '0 : word_in_line + 1'b1;
            end
        end
    end

    // Registered stream output: markers describe the word popped in the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
            sof   <= 1'b0;
            eof   <= 1'b0;
        end else begin
            valid <= fifo_pop;
            if (fifo_pop) begin
                data <= fifo_data;
                sop  <= (word_in_line == '0);
                eop  <= (word_in_line == LINE_LAST);
                sof  <= (tx_cnt == '0);
                eof  <= (tx_cnt == LAST_C);
            end else begin
                sop  <= 1'b0;
                eop  <= 1'b0;
                sof  <= 1'b0;
                eof  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_frame_reader.sv
// Bench for sdram_frame_reader: SDRAM slave model, stream scoreboard and directed scenarios.
// The slave accepts requests after a programmable number of wait cycles and returns bursts back-to-back.
// Expected stream words are queued when a frame is started and retired as the DUT emits them.
module tb_sdram_frame_reader;
    localparam int LINE_WORDS_P = 5;
    localparam int LINES_P      = 3;
    localparam int BURST_P      = 4;
    localparam int DEPTH_P      = 8;
    localparam int TOTAL        = LINE_WORDS_P * LINES_P;
    localparam int NBURSTS      = (TOTAL + BURST_P - 1) / BURST_P;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  flags;   // {sop, eop, sof, eof}
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  cnt;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        out_enable = 1'b1;
    logic        busy, done;
    logic [31:0] address;
    logic [7:0]  burstcount;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [63:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic [63:0] data;
    logic        valid, sop, eop, sof, eof;

    int          n_assert = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    burst_t      burst_log[$];
    logic [63:0] ret_q[$];
    int          n_ret = 0;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    logic        held = 1'b0;
    logic [31:0] held_addr = '0;
    logic [7:0]  held_bc = '0;
    logic        eof_prev = 1'b0;

    sdram_frame_reader #(
        .WIDTH_ADDR (32),
        .WIDTH_DATA (64),
        .BURST_LEN  (BURST_P),
        .LINE_WORDS (LINE_WORDS_P),
        .LINES      (LINES_P),
        .FIFO_DEPTH (DEPTH_P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .out_enable    (out_enable),
        .busy          (busy),
        .done          (done),
        .address       (address),
        .burstcount    (burstcount),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .data          (data),
        .valid         (valid),
        .sop           (sop),
        .eop           (eop),
        .sof           (sof),
        .eof           (eof)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a + 32'h0000_1234};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // SDRAM slave: return path first, then request acceptance (data starts on the following cycle).
    always @(negedge clk) begin
        if (ret_q.size() > 0) begin
            readdatavalid = 1'b1;
            readdata      = ret_q.pop_front();
            n_ret++;
            if (busy && !reset)
                check("fifo_room_on_push", 64'(dut.fifo_used < 4'(DEPTH_P)), 64'(1));
        end else begin
            readdatavalid = 1'b0;
            readdata      = '0;
        end
        if (read === 1'b1) begin
            if (held) begin
                check("req_addr_stable", 64'(address), 64'(held_addr));
                check("req_bc_stable", 64'(burstcount), 64'(held_bc));
            end
            if (wait_cnt < wait_cycles) begin
                waitrequest = 1'b1;
                wait_cnt++;
                held      = 1'b1;
                held_addr = address;
                held_bc   = burstcount;
            end else begin
                waitrequest = 1'b0;
                wait_cnt    = 0;
                held        = 1'b0;
                burst_log.push_back('{address, burstcount});
                for (int i = 0; i < int'(burstcount); i++)
                    ret_q.push_back(mem_word(address + 32'(i)));
            end
        end else begin
            waitrequest = 1'b0;
            wait_cnt    = 0;
            held        = 1'b0;
        end
    end

    // Stream monitor: retire expected words and check done/busy one cycle after eof.
    always @(negedge clk) begin
        if (reset) begin
            eof_prev = 1'b0;
        end else begin
            if (done || eof_prev)
                check("done_after_eof", 64'({done, busy}), 64'({eof_prev, 1'b0}));
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_word", 64'(valid), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("stream_data", data, e.data);
                    check("stream_flags", 64'({sop, eop, sof, eof}), 64'(e.flags));
                end
            end
            eof_prev = valid && eof;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        base_addr = base;
        start     = 1'b1;
        for (int i = 0; i < TOTAL; i++) begin
            exp_t e;
            e.data  = mem_word(base + 32'(i));
            e.flags = {(i % LINE_WORDS_P) == 0, (i % LINE_WORDS_P) == LINE_WORDS_P - 1,
                       i == 0, i == TOTAL - 1};
            exp_q.push_back(e);
        end
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            step(1);
            cyc++;
        end
        check(tag, 64'(done), 64'(1));
        step(1);
    endtask

    task automatic check_log(input logic [31:0] base);
        check("burst_total", 64'(burst_log.size()), 64'(NBURSTS));
        for (int k = 0; k < burst_log.size() && k < NBURSTS; k++) begin
            int rem = TOTAL - k * BURST_P;
            check("burst_addr", 64'(burst_log[k].addr), 64'(base + 32'(k * BURST_P)));
            check("burst_cnt", 64'(burst_log[k].cnt), 64'((rem > BURST_P) ? BURST_P : rem));
        end
    endtask

    task automatic check_idle_outputs();
        check("idle_read", 64'(read), 64'(0));
        check("idle_address", 64'(address), 64'(0));
        check("idle_burstcount", 64'(burstcount), 64'(0));
        check("idle_stream_ctl", 64'({valid, sop, eop, sof, eof}), 64'(0));
        check("idle_data", data, 64'(0));
        check("idle_busy_done", 64'({busy, done}), 64'(0));
        check("idle_fifo_empty", 64'(dut.fifo_used), 64'(0));
    endtask

    // Overall guard against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int nvalid;

        // Reset state
        reset = 1'b1;
        step(3);
        check_idle_outputs();
        reset = 1'b0;
        step(1);

        // Basic frame at 0x100 with first-read timing
        burst_log.delete();
        do_start(32'h100);
        check("start_busy", 64'(busy), 64'(1));
        check("read_not_yet", 64'(read), 64'(0));
        step(1);
        check("first_read", 64'(read), 64'(1));
        check("first_address", 64'(address), 64'(32'h100));
        check("first_burstcount", 64'(burstcount), 64'(BURST_P));
        wait_done("frame1_done");
        check_log(32'h100);
        check("frame1_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure: output paused, only two bursts fit the FIFO
        burst_log.delete();
        out_enable = 1'b0;
        do_start(32'h2000);
        nvalid = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (valid) nvalid++;
        end
        check("bp_bursts", 64'(burst_log.size()), 64'(2));
        check("bp_read_low", 64'(read), 64'(0));
        check("bp_no_output", 64'(nvalid), 64'(0));
        out_enable = 1'b1;
        wait_done("bp_done");
        check_log(32'h2000);
        check("bp_drained", 64'(exp_q.size()), 64'(0));

        // waitrequest held 5 cycles on every request
        burst_log.delete();
        wait_cycles = 5;
        do_start(32'h300);
        wait_done("wait_done");
        check_log(32'h300);
        check("wait_drained", 64'(exp_q.size()), 64'(0));
        wait_cycles = 0;

        // start while busy is ignored; a second start after done reruns the frame
        burst_log.delete();
        do_start(32'h400);
        step(3);
        base_addr = 32'h999;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
        wait_done("busy_start_done");
        check_log(32'h400);
        check("busy_start_drained", 64'(exp_q.size()), 64'(0));
        burst_log.delete();
        do_start(32'h400);
        wait_done("rerun_done");
        check_log(32'h400);
        check("rerun_drained", 64'(exp_q.size()), 64'(0));

        // Reset after the third received word while the slave keeps returning data
        burst_log.delete();
        n_ret = 0;
        do_start(32'h500);
        cyc = 0;
        while (n_ret < 3 && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("rst_third_word_seen", 64'(n_ret >= 3), 64'(1));
        reset = 1'b1;
        step(1);
        check_idle_outputs();
        exp_q.delete();
        step(1);
        reset = 1'b0;
        cyc = 0;
        while (ret_q.size() > 0 && cyc < 100) begin
            step(1);
            cyc++;
        end
        step(2);
        check("stale_returns_done", 64'(ret_q.size()), 64'(0));
        check("stale_dropped", 64'(dut.fifo_used), 64'(0));
        burst_log.delete();
        do_start(32'h600);
        wait_done("post_reset_done");
        check_log(32'h600);
        check("post_reset_drained", 64'(exp_q.size()), 64'(0));

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
